// File: rtl/fetch_align_unit.sv
// fetch_align_unit: instruction fetch front-end. It reads 32-bit ROM words into a halfword prefetch queue
// and presents one aligned instruction (16-bit RVC or 32-bit, word-spanning allowed) per valid/ready handshake.
// Ports:
//   iCLK/iRST: clock and async active-high reset.
//   oROM_CE/oROM_RD/oROM_ADDR/iROM_DATA: 1-cycle synchronous ROM read port.
//   iREDIRECT/iREDIRECT_PC: redirect from execute.
//   oIR_VALID/iIR_READY/oIR/oIR_PC/oIR_IS_C: decode handshake.
//   oMISALIGN: sticky misalign flag. oQ_LEVEL: queue occupancy in halfwords.
// Latency: the first instruction is valid 2 edges after reset release or after a redirect.
// Backpressure: the queue holds while ready is low, and ROM requests stop once the queue plus the pending push
// leaves fewer than 2 free entries.
// Optional feature macro FETCH_RVC_EN: when defined, 16-bit compressed instructions are decoded. When it is
// undefined, every instruction is 32-bit and a target that is not word-aligned is flagged as misaligned.
module fetch_align_unit #(
  parameter int ADDR_W = 8,
  parameter int QDEPTH = 8,
  parameter logic [ADDR_W-1:0] BOOT_PC = '0
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  output logic                      oROM_CE,
  output logic                      oROM_RD,
  output logic [ADDR_W-3:0]         oROM_ADDR,
  input  logic [31:0]               iROM_DATA,
  input  logic                      iREDIRECT,
  input  logic [ADDR_W-1:0]         iREDIRECT_PC,
  output logic                      oIR_VALID,
  input  logic                      iIR_READY,
  output logic [31:0]               oIR,
  output logic [ADDR_W-1:0]         oIR_PC,
  output logic                      oIR_IS_C,
  output logic                      oMISALIGN,
  output logic [$clog2(QDEPTH):0]   oQ_LEVEL
);

  localparam int PW = $clog2(QDEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW:0] QD_EXT = (LW+1)'(QDEPTH);

  logic [15:0]       q_mem [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_p1, rd_ptr_p1;
  logic [LW-1:0]     level;
  logic [ADDR_W-1:0] fpc, dpc;
  logic              in_flight;  // a ROM word lands on the next edge
  logic              stale;      // the landing word belongs to a path that was redirected away
  logic              skip_low;   // next useful word starts at its high half (target pc[1]=1)
  logic              misalign;

  logic [15:0] head, head_nxt;
  logic        is_c;
  logic        ir_valid;
  logic        fire;
  logic        land;
  logic [1:0]  push_cnt, pop_cnt;
  logic        room_ok;
  logic        rom_rd;
  logic        redirect_bad;

  assign wr_ptr_p1 = wr_ptr + PW'(1);
  assign rd_ptr_p1 = rd_ptr + PW'(1);
  assign head      = q_mem[rd_ptr];
  assign head_nxt  = q_mem[rd_ptr_p1];

`ifdef FETCH_RVC_EN
  assign is_c         = (head[1:0] != 2'b11);
  assign redirect_bad = iREDIRECT_PC[0];
`else
  assign is_c         = 1'b0;
  assign redirect_bad = |iREDIRECT_PC[1:0];
`endif

  // A 16-bit instruction needs one entry; a 32-bit one needs both halves present.
  assign ir_valid = !misalign && (is_c ? (level != '0) : (level >= LW'(2)));
  assign fire     = ir_valid && iIR_READY;
  assign pop_cnt  = fire ? (is_c ? 2'd1 : 2'd2) : 2'd0;

  // With a 1-cycle ROM, an in-flight word always lands on the next edge, so a new request can
  // issue every cycle. The only limit is room for the landing word plus the new one; pops this
  // cycle are ignored, which keeps the check conservative.
  assign land     = in_flight && !stale;
  assign push_cnt = land ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
  assign room_ok  = ({1'b0, level} + (LW+1)'(push_cnt) + (LW+1)'(2)) <= QD_EXT;
  assign rom_rd   = !iRST && !misalign && room_ok;

  assign oROM_RD   = rom_rd;
  assign oROM_CE   = rom_rd;
  assign oROM_ADDR = rom_rd ? fpc[ADDR_W-1:2] : '0;
  assign oIR_VALID = ir_valid;
  assign oIR       = ir_valid ? (is_c ? {16'h0000, head} : {head_nxt, head}) : 32'h0;
  assign oIR_PC    = ir_valid ? dpc : '0;
  assign oIR_IS_C  = ir_valid && is_c;
  assign oMISALIGN = misalign;
  assign oQ_LEVEL  = level;

  // Queue storage is not reset; occupancy is tracked by the pointers and the level.
  always_ff @(posedge iCLK) begin
    if (land && !iREDIRECT) begin
      if (skip_low) begin
        q_mem[wr_ptr] <= iROM_DATA[31:16];
      end else begin
        q_mem[wr_ptr]    <= iROM_DATA[15:0];
        q_mem[wr_ptr_p1] <= iROM_DATA[31:16];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      fpc       <= {BOOT_PC[ADDR_W-1:2], 2'b00};
      dpc       <= BOOT_PC;
      in_flight <= 1'b0;
      stale     <= 1'b0;
      skip_low  <= BOOT_PC[1];
      misalign  <= 1'b0;
    end else if (iREDIRECT) begin
      // The redirect wins over this edge's push and pop. A request issued on this edge still
      // returns old-path data next cycle, so it is marked stale.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      fpc       <= {iREDIRECT_PC[ADDR_W-1:2], 2'b00};
      dpc       <= iREDIRECT_PC;
      in_flight <= rom_rd;
      stale     <= rom_rd;
      skip_low  <= iREDIRECT_PC[1];
      misalign  <= redirect_bad;
    end else begin
      in_flight <= rom_rd;
      stale     <= 1'b0;
      if (rom_rd) fpc <= fpc + ADDR_W'(4);
      if (land) skip_low <= 1'b0;
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      level  <= level + LW'(push_cnt) - LW'(pop_cnt);
      if (fire) dpc <= dpc + (is_c ? ADDR_W'(2) : ADDR_W'(4));
    end
  end

endmodule

// File: tb/tb_fetch_align_unit.sv
module tb_fetch_align_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce, rom_rd;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_is_c, misalign;
  logic [3:0]  q_level;
  logic [31:0] rom [64];
  int vectors = 0;
  int miscompares = 0;

  fetch_align_unit #(.ADDR_W(8), .QDEPTH(8), .BOOT_PC(8'h00)) dut (
    .iCLK(clk), .iRST(rst),
    .oROM_CE(rom_ce), .oROM_RD(rom_rd), .oROM_ADDR(rom_addr), .iROM_DATA(rom_data),
    .iREDIRECT(redirect), .iREDIRECT_PC(redirect_pc),
    .oIR_VALID(ir_valid), .iIR_READY(ir_ready), .oIR(ir), .oIR_PC(ir_pc), .oIR_IS_C(ir_is_c),
    .oMISALIGN(misalign), .oQ_LEVEL(q_level)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous ROM
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  function automatic logic [31:0] word(int i);
    return 32'hC0DE_0013 | (32'(i) << 8);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 64; i++) rom[i] = word(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ir_ready = 1'b0;
    rst = 1'b1;
    tick();
    vectors++; if (rom_rd !== 1'b0) begin miscompares++; $display("FAIL reset_rom_rd: got %b want 0", rom_rd); end
    vectors++; if (rom_ce !== 1'b0) begin miscompares++; $display("FAIL reset_rom_ce: got %b want 0", rom_ce); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    vectors++; if (ir !== 32'h0 || ir_pc !== 8'h0) begin miscompares++; $display("FAIL reset_ir: got %h@%h want 0@0", ir, ir_pc); end
    vectors++; if (q_level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", q_level); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b want 0", misalign); end
  endtask

  task automatic test_basic();
    fill_rom(); rom[0] = 32'h00000013; rom[1] = 32'h00100093;
    ir_ready = 1'b1;
    rst = 1'b0;
    tick();
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b want 0", ir_valid); end
    vectors++; if (rom_rd !== 1'b1 || rom_addr !== 6'd1) begin miscompares++; $display("FAIL basic_req: got rd=%b addr=%0d want rd=1 addr=1", rom_rd, rom_addr); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== 32'h00000013 || ir_pc !== 8'h00 || ir_is_c !== 1'b0) begin
      miscompares++; $display("FAIL basic_first: got v=%b %h@%h c=%b want v=1 00000013@00 c=0", ir_valid, ir, ir_pc, ir_is_c); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== 32'h00100093 || ir_pc !== 8'h04 || ir_is_c !== 1'b0) begin
      miscompares++; $display("FAIL basic_second: got v=%b %h@%h c=%b want v=1 00100093@04 c=0", ir_valid, ir, ir_pc, ir_is_c); end
    vectors++; if (q_level !== 4'd2) begin miscompares++; $display("FAIL basic_level: got %0d want 2", q_level); end
  endtask

`ifdef FETCH_RVC_EN
  task automatic test_rvc();
    fill_rom(); rom[0] = 32'h45014581;
    ir_ready = 1'b1; do_reset();
    tick(); tick();
    vectors++; if (ir !== 32'h00004581 || ir_pc !== 8'h00 || ir_is_c !== 1'b1) begin
      miscompares++; $display("FAIL rvc_a0: got %h@%h c=%b want 00004581@00 c=1", ir, ir_pc, ir_is_c); end
    tick();
    vectors++; if (ir !== 32'h00004501 || ir_pc !== 8'h02 || ir_is_c !== 1'b1) begin
      miscompares++; $display("FAIL rvc_a1: got %h@%h c=%b want 00004501@02 c=1", ir, ir_pc, ir_is_c); end
    rom[0] = 32'h00134581; rom[1] = 32'h45010000;
    do_reset();
    tick(); tick();
    vectors++; if (ir !== 32'h00004581 || ir_pc !== 8'h00) begin miscompares++; $display("FAIL rvc_b0: got %h@%h want 00004581@00", ir, ir_pc); end
    tick();
    vectors++; if (ir !== 32'h00000013 || ir_pc !== 8'h02 || ir_is_c !== 1'b0) begin
      miscompares++; $display("FAIL rvc_span: got %h@%h c=%b want 00000013@02 c=0", ir, ir_pc, ir_is_c); end
    tick();
    vectors++; if (ir !== 32'h00004501 || ir_pc !== 8'h06 || ir_is_c !== 1'b1) begin
      miscompares++; $display("FAIL rvc_b2: got %h@%h c=%b want 00004501@06 c=1", ir, ir_pc, ir_is_c); end
  endtask
`endif

  task automatic test_backpressure();
    int k;
    fill_rom(); ir_ready = 1'b0; do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ir_valid) begin
        vectors++; if (ir !== word(0) || ir_pc !== 8'h00) begin miscompares++; $display("FAIL bp_stable: got %h@%h want %h@00", ir, ir_pc, word(0)); end
      end
      if (q_level == 4'd8) begin
        vectors++; if (rom_rd !== 1'b0) begin miscompares++; $display("FAIL bp_full_rd: got %b want 0", rom_rd); end
      end
    end
    vectors++; if (q_level !== 4'd8) begin miscompares++; $display("FAIL bp_level: got %0d want 8", q_level); end
    vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b want 1", ir_valid); end
    ir_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      if (ir_valid) begin
        vectors++; if (ir !== word(k) || ir_pc !== 8'(4*k)) begin
          miscompares++; $display("FAIL bp_resume: got %h@%h want %h@%h", ir, ir_pc, word(k), 8'(4*k)); end
        k++;
      end
      tick();
    end
    vectors++; if (k != 10) begin miscompares++; $display("FAIL bp_timeout: got %0d instrs want 10", k); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_ir;
    logic [7:0]  exp_pc;
    bit got;
    fill_rom();
`ifdef FETCH_RVC_EN
    rom[8] = 32'h4581_0813; exp_ir = 32'h00004581; exp_pc = 8'h22;
`else
    exp_ir = word(8); exp_pc = 8'h20;
`endif
    ir_ready = 1'b1; do_reset();
    repeat (4) tick();
    vectors++; if (rom_rd !== 1'b1) begin miscompares++; $display("FAIL redir_inflight: got %b want 1", rom_rd); end
    redirect = 1'b1; redirect_pc = exp_pc;
    tick();
    redirect = 1'b0;
    vectors++; if (q_level !== 4'd0 || ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_flush: got level=%0d v=%b want 0 0", q_level, ir_valid); end
    got = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      tick();
      if (ir_valid) got = 1'b1;
    end
    vectors++; if (!got) begin miscompares++; $display("FAIL redir_timeout: got no valid want valid within 3 edges"); end
    vectors++; if (ir !== exp_ir || ir_pc !== exp_pc) begin miscompares++; $display("FAIL redir_first: got %h@%h want %h@%h", ir, ir_pc, exp_ir, exp_pc); end
    tick();
    vectors++; if (ir !== word(9) || ir_pc !== 8'h24) begin miscompares++; $display("FAIL redir_next: got %h@%h want %h@24", ir, ir_pc, word(9)); end
  endtask

  task automatic test_misalign();
    bit got;
    fill_rom(); ir_ready = 1'b1; do_reset();
    repeat (3) tick();
    redirect = 1'b1;
`ifdef FETCH_RVC_EN
    redirect_pc = 8'h05;
`else
    redirect_pc = 8'h06;
`endif
    tick();
    redirect = 1'b0;
    vectors++; if (misalign !== 1'b1 || ir_valid !== 1'b0) begin
      miscompares++; $display("FAIL mis_set: got m=%b v=%b want m=1 v=0", misalign, ir_valid); end
    repeat (4) tick();
    vectors++; if (misalign !== 1'b1 || ir_valid !== 1'b0 || rom_rd !== 1'b0) begin
      miscompares++; $display("FAIL mis_hold: got m=%b v=%b rd=%b want 1 0 0", misalign, ir_valid, rom_rd); end
    redirect = 1'b1; redirect_pc = 8'h08;
    tick();
    redirect = 1'b0;
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", misalign); end
    got = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      tick();
      if (ir_valid) got = 1'b1;
    end
    vectors++; if (!got || ir !== word(2) || ir_pc !== 8'h08) begin
      miscompares++; $display("FAIL mis_resume: got v=%b %h@%h want v=1 %h@08", got, ir, ir_pc, word(2)); end
  endtask

  task automatic test_reset_mid();
    fill_rom(); ir_ready = 1'b1; do_reset();
    repeat (5) tick();
    rst = 1'b1;
    #1;
    vectors++; if (rom_rd !== 1'b0 || ir_valid !== 1'b0 || q_level !== 4'd0 || ir !== 32'h0 || ir_pc !== 8'h0) begin
      miscompares++; $display("FAIL rstmid_outputs: got rd=%b v=%b lvl=%0d ir=%h pc=%h want all 0", rom_rd, ir_valid, q_level, ir, ir_pc); end
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_early: got %b want 0", ir_valid); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== word(0) || ir_pc !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_restart: got v=%b %h@%h want v=1 %h@00", ir_valid, ir, ir_pc, word(0)); end
  endtask

  initial begin
    fill_rom();
    #2 rst = 1'b1;
    test_reset();
    test_basic();
`ifdef FETCH_RVC_EN
    test_rvc();
`endif
    test_backpressure();
    test_redirect();
    test_misalign();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
